// File: rtl/gpi_pkg.sv
// Shared register map constants for the general-purpose input port.
// Optional build macro: GPI_DEBOUNCE_EN (per-pin stability filter).
package gpi_pkg;

  localparam logic [1:0] ADDR_IDR = 2'd0;
  localparam logic [1:0] ADDR_IER = 2'd1;
  localparam logic [1:0] ADDR_ISR = 2'd2;
  localparam logic [1:0] ADDR_ECR = 2'd3;

  // Falling-edge enables live in the upper half of ECR.
  localparam int ECR_FALL_LSB = 16;
  localparam int BUS_W        = 32;

endpackage

// File: rtl/gpi_debounce.sv
// One input pin: synchroniser chain followed by an optional stability filter.
// The filtered level register is this pin's IDR bit; level_next feeds edge detection.
module gpi_debounce
  import gpi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic level_next
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef GPI_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_next;

  // The counter only runs while the synced value disagrees with the accepted level.
  always_comb begin
    level_next = level_q;
    cnt_next   = '0;
    if (synced != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) level_next = synced;
      else                             cnt_next   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_next;
  end
`else
  always_comb begin
    level_next = synced;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level_next;
  end

  assign level = level_q;

endmodule

// File: rtl/gpi_capture.sv
// Memory-mapped GPI port: live pin levels, W1C edge capture and a level interrupt.
// Optional build macro: GPI_DEBOUNCE_EN enables per-pin debounce in gpi_debounce.
module gpi_capture
  import gpi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              wr,
  input  logic [1:0]        addr,
  input  logic [BUS_W-1:0]  wdata,
  output logic [BUS_W-1:0]  rdata,
  input  logic [WIDTH-1:0]  gpi,
  output logic              irq
);

  logic [WIDTH-1:0] idr;
  logic [WIDTH-1:0] idr_next;
  logic [WIDTH-1:0] ier;
  logic [WIDTH-1:0] isr;
  logic [WIDTH-1:0] ecr_rise;
  logic [WIDTH-1:0] ecr_fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] isr_kept;
  logic             we;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpi_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_pin (
      .clk        (clk),
      .rst        (rst),
      .pin        (gpi[i]),
      .level      (idr[i]),
      .level_next (idr_next[i])
    );
  end

  assign we = cs & wr;

  // Edges are judged on the IDR transition itself, so ISR sets on the same edge IDR moves.
  assign edge_hit = (idr_next & ~idr & ecr_rise) | (~idr_next & idr & ecr_fall);

  // A new edge is OR'ed in after the W1C mask, so a simultaneous set wins.
  assign isr_kept = (we && addr == ADDR_ISR) ? (isr & ~wdata[WIDTH-1:0]) : isr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ier      <= '0;
      isr      <= '0;
      ecr_rise <= '0;
      ecr_fall <= '0;
      irq      <= 1'b0;
    end else begin
      if (we && addr == ADDR_IER) ier <= wdata[WIDTH-1:0];
      if (we && addr == ADDR_ECR) begin
        ecr_rise <= wdata[WIDTH-1:0];
        ecr_fall <= wdata[ECR_FALL_LSB +: WIDTH];
      end
      isr <= isr_kept | edge_hit;
      irq <= |(isr & ier);
    end
  end

  always_comb begin
    rdata = '0;
    if (cs) begin
      case (addr)
        ADDR_IDR: rdata[WIDTH-1:0] = idr;
        ADDR_IER: rdata[WIDTH-1:0] = ier;
        ADDR_ISR: rdata[WIDTH-1:0] = isr;
        default: begin
          rdata[WIDTH-1:0]                 = ecr_rise;
          rdata[ECR_FALL_LSB +: WIDTH]     = ecr_fall;
        end
      endcase
    end
  end

  // Bus bits above the pin count are ignored on write.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata};

endmodule

// File: tb/tb_gpi_capture.sv
// Bench for gpi_capture: directed register/edge scenarios plus randomized pins and bus traffic.
module tb_gpi_capture;
  import gpi_pkg::*;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int DB    = 16;
`ifdef GPI_DEBOUNCE_EN
  localparam int LAT = SYNC + DB;
`else
  localparam int LAT = SYNC + 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cs, wr;
  logic [1:0]        addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [WIDTH-1:0]  gpi;
  logic              irq;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpi_capture #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC),
    .DB_CYCLES   (DB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .cs    (cs),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .gpi   (gpi),
    .irq   (irq)
  );

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_idr, m_ier, m_isr, m_rise, m_fall;
  logic             m_irq;
  logic [WIDTH-1:0] hist[$];
  int               run[WIDTH];

  always @(posedge clk or posedge rst) begin : model
    logic [WIDTH-1:0] seen, nidr, edges;
    if (rst) begin
      m_idr = '0; m_ier = '0; m_isr = '0; m_rise = '0; m_fall = '0; m_irq = 1'b0;
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back('0);
      for (int i = 0; i < WIDTH; i++) run[i] = 0;
    end else begin
      // Pin level as it arrives after the synchroniser delay.
      hist.push_back(gpi);
      seen = hist.pop_front();
`ifdef GPI_DEBOUNCE_EN
      nidr = m_idr;
      for (int i = 0; i < WIDTH; i++) begin
        if (seen[i] != m_idr[i]) begin
          if (run[i] == DB - 1) begin nidr[i] = seen[i]; run[i] = 0; end
          else run[i] = run[i] + 1;
        end else run[i] = 0;
      end
`else
      nidr = seen;
`endif
      edges = (nidr & ~m_idr & m_rise) | (~nidr & m_idr & m_fall);
      m_irq = |(m_isr & m_ier);
      if (cs && wr) begin
        case (addr)
          2'd1: m_ier = wdata[WIDTH-1:0];
          2'd2: m_isr = m_isr & ~wdata[WIDTH-1:0];
          2'd3: begin m_rise = wdata[WIDTH-1:0]; m_fall = wdata[16 +: WIDTH]; end
          default: ;
        endcase
      end
      m_isr = m_isr | edges;
      m_idr = nidr;
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0: v[WIDTH-1:0] = m_idr;
      2'd1: v[WIDTH-1:0] = m_ier;
      2'd2: v[WIDTH-1:0] = m_isr;
      default: begin v[WIDTH-1:0] = m_rise; v[16 +: WIDTH] = m_fall; end
    endcase
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("irq_model", {31'b0, irq}, {31'b0, m_irq});
      chk("rdata_model", rdata, cs ? model_read(addr) : 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    tick();
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
    cs = 1'b1; addr = a;
    @(negedge clk);
    chk(name, rdata, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cs = 1'b0; wr = 1'b0; addr = 2'd0; wdata = '0; gpi = 8'hA5;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Reset with pins held: IDR picks up A5 after the latency, no capture with ECR=0.
    cs = 1'b1; addr = ADDR_IDR;
    repeat (LAT - 1) tick();
    rd_chk(ADDR_IDR, 32'h0, "idr_before_latency");
    tick();
    rd_chk(ADDR_IDR, 32'h0000_00A5, "idr_after_reset");
    rd_chk(ADDR_ISR, 32'h0, "isr_after_reset");
    chk("irq_after_reset", {31'b0, irq}, 32'h0);

    // Rising edge on pin 0 with interrupt enabled, then W1C.
    wr_reg(ADDR_ECR, 32'h0000_0001);
    wr_reg(ADDR_IER, 32'h0000_0001);
    gpi = 8'hA4;
    repeat (LAT + 2) tick();
    rd_chk(ADDR_ISR, 32'h0, "isr_fall_not_enabled");
    tick();
    gpi = 8'hA5;
    repeat (LAT - 1) tick();
    rd_chk(ADDR_ISR, 32'h0, "isr_before_rise");
    tick();
    rd_chk(ADDR_ISR, 32'h1, "isr_rise0");
    chk("irq_lags_isr", {31'b0, irq}, 32'h0);
    tick();
    rd_chk(ADDR_ISR, 32'h1, "isr_rise0_held");
    chk("irq_set", {31'b0, irq}, 32'h1);
    wr_reg(ADDR_ISR, 32'h1);
    rd_chk(ADDR_ISR, 32'h0, "isr_w1c");
    tick();
    rd_chk(ADDR_ISR, 32'h0, "isr_w1c_held");
    chk("irq_cleared", {31'b0, irq}, 32'h0);

    // Falling-edge capture on pin 7, rising ignored, no irq without IER[7].
    wr_reg(ADDR_ECR, 32'h0080_0000);
    rd_chk(ADDR_ECR, 32'h0080_0000, "ecr_readback");
    tick();
    gpi = 8'h25;
    repeat (LAT + 1) tick();
    rd_chk(ADDR_ISR, 32'h80, "isr_fall7");
    chk("irq_masked7", {31'b0, irq}, 32'h0);
    tick();
    gpi = 8'hA5;
    repeat (LAT + 1) tick();
    rd_chk(ADDR_ISR, 32'h80, "isr_rise7_ignored");
    chk("irq_still_masked7", {31'b0, irq}, 32'h0);
    wr_reg(ADDR_IDR, 32'hFFFF_FFFF);
    rd_chk(ADDR_IDR, 32'h0000_00A5, "idr_write_ignored");
    wr_reg(ADDR_ISR, 32'hFF);

`ifdef GPI_DEBOUNCE_EN
    // Short glitch on pin 3 filtered out; long pulse accepted after SYNC+DB cycles.
    wr_reg(ADDR_ECR, 32'h0000_0008);
    tick();
    gpi = 8'hAD;
    repeat (10) tick();
    gpi = 8'hA5;
    repeat (LAT + 5) tick();
    rd_chk(ADDR_IDR, 32'h0000_00A5, "db_glitch_idr");
    rd_chk(ADDR_ISR, 32'h0, "db_glitch_isr");
    tick();
    gpi = 8'hAD;
    repeat (LAT - 1) tick();
    rd_chk(ADDR_IDR, 32'h0000_00A5, "db_pulse_pending");
    tick();
    rd_chk(ADDR_IDR, 32'h0000_00AD, "db_pulse_idr");
    repeat (20 - LAT) tick();
    gpi = 8'hA5;
    repeat (LAT + 2) tick();
    wr_reg(ADDR_ISR, 32'hFF);
`endif

    // W1C coinciding with a new rising edge: set wins.
    wr_reg(ADDR_ECR, 32'h0000_0001);
    gpi = 8'hA4;
    repeat (LAT + 1) tick();
    rd_chk(ADDR_ISR, 32'h0, "isr_clean_before_race");
    tick();
    gpi = 8'hA5;
    repeat (LAT - 1) tick();
    cs = 1'b1; wr = 1'b1; addr = ADDR_ISR; wdata = 32'h1;
    tick();
    wr = 1'b0;
    rd_chk(ADDR_ISR, 32'h1, "isr_set_wins");
    tick();
    @(negedge clk);
    chk("irq_before_async_rst", {31'b0, irq}, 32'h1);

    // Asynchronous reset mid-cycle clears everything immediately.
    #1 rst = 1'b1;
    #1 chk("irq_async_rst", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1 chk("rdata_async_rst", rdata, 32'h0);
    end
    @(posedge clk);
    #2 rst = 1'b0;

    // Randomized pins and bus traffic, checked every cycle against the model.
    for (int n = 0; n < 1500; n++) begin
      tick();
`ifdef GPI_DEBOUNCE_EN
      if ($urandom_range(0, 24) == 0) gpi = WIDTH'($urandom());
`else
      if ($urandom_range(0, 3) == 0) gpi = WIDTH'($urandom());
`endif
      cs    = ($urandom_range(0, 4) != 0);
      wr    = ($urandom_range(0, 3) == 0);
      addr  = 2'($urandom_range(0, 3));
      wdata = $urandom();
    end
    cs = 1'b0; wr = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
